// File: rtl/flash_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : flash_loader_pkg
// Purpose : Shared definitions for the boot-time flash loader.
//           Holds the loader state encoding, the byte-index width used
//           by the byte packer, and the default flash geometry. The flash
//           macro and the loader both take their geometry from here, so
//           they agree on it.
// Rev     : 1.0  initial release
// ============================================================================
package flash_loader_pkg;

  // Default flash geometry, in 32-bit words.
  localparam int unsigned FL_ADDR_W  = 15;
  localparam int unsigned FL_DEPTH   = 32768;

  // Width of the byte-within-word index. A word holds 4 bytes.
  localparam int unsigned BYTE_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_SUM  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/flash_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : byte_packer
// Purpose : Packs accepted bytes little-endian into a 32-bit word.
//           'word' is the word that would result if the byte now on
//           byte_in were taken as the next byte. word_valid pulses
//           combinationally on the cycle the 4th byte is taken. The
//           2-byte length field can therefore be read from word[31:16]
//           when byte_idx==1.
// Ports   : clk, rst      clock, synchronous active-high reset
//           clear         drop any partial word (priority over byte_valid)
//           byte_valid    byte_in is taken this cycle
//           byte_in[7:0]  incoming byte
//           byte_idx      number of bytes already held (0..3)
//           word[31:0]    packed word including byte_in
//           word_valid    4th byte taken this cycle
// Rev     : 1.0  initial release
// ============================================================================
module byte_packer
  import flash_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  output logic [BYTE_IDX_W-1:0] byte_idx,
  output logic [31:0]           word,
  output logic                  word_valid
);

  // Only the 3 earlier bytes need storage. The 4th byte comes straight
  // from byte_in.
  logic [23:0]           shift_q, shift_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_valid) begin
      // Shifting right puts the oldest byte at the bottom, which gives
      // little-endian order.
      shift_d = {byte_in, shift_q[23:8]};
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_idx   = idx_q;
  assign word       = {byte_in, shift_q};
  assign word_valid = byte_valid && !clear && (&idx_q);

endmodule
`default_nettype wire

// File: rtl/flash_loader.sv
`default_nettype none
// ============================================================================
// Module  : flash_loader
// Purpose : Boot-time loader. It receives an image over a UART byte stream
//           and writes it to on-chip flash at word addresses 0..N-1. The
//           CPU is held in reset while the load runs.
//           Stream format: N[15:0] little-endian, then N words, each
//           little-endian. When FLASH_LOADER_CHECKSUM_EN is defined, a
//           32-bit little-endian checksum follows. It must equal the
//           mod-2^32 sum of the words.
// Ports   : clk, rst           clock, synchronous active-high reset
//           start              pulse to begin a load (ignored while busy)
//           rx_data/rx_valid   byte stream from the UART receiver
//           rx_ready           byte accepted when rx_valid && rx_ready
//           flash_addra/dina   flash write address/data
//           flash_wea          one-cycle write strobe per word
//           cpu_rst            CPU held in reset until a load has ended
//           busy               a load is in progress
//           done               one-cycle pulse at the end of a load
//           error              sticky failure flag, cleared by start/rst
//           words_wr           words written in the current load
// Config  : FLASH_LOADER_CHECKSUM_EN  adds the trailing checksum field
// Rev     : 1.0  initial release
// ============================================================================
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = FL_ADDR_W,
  parameter int unsigned DEPTH   = FL_DEPTH,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] flash_addra,
  output logic [31:0]       flash_dina,
  output logic              flash_wea,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_wr
);

  localparam int unsigned    TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     words_wr_q, words_wr_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [31:0]         dina_q, dina_d;
  logic                error_q, error_d;
  logic                loaded_q, loaded_d;
`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [31:0]         sum_q, sum_d;
`endif

  logic                  busy_w;
  logic                  accept;
  logic                  pk_clear;
  logic [BYTE_IDX_W-1:0] pk_idx;
  logic [31:0]           pk_word;
  logic                  pk_valid;
  logic [31:0]           len32;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (accept),
    .byte_in    (rx_data),
    .byte_idx   (pk_idx),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  assign busy_w   = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_SUM);
  // No byte is taken while a word write is outstanding. A data word
  // therefore costs 5 cycles.
  assign rx_ready = busy_w && !wea_q;
  assign accept   = rx_valid && rx_ready;
  assign len32    = {16'd0, pk_word[31:16]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    words_wr_d = words_wr_q;
    to_cnt_d   = to_cnt_q;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;
    error_d    = error_q;
    loaded_d   = loaded_q;
    pk_clear   = 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LEN;
          error_d    = 1'b0;
          words_wr_d = '0;
          addra_d    = '0;
          to_cnt_d   = '0;
          pk_clear   = 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end

      ST_LEN: begin
        if (accept && (pk_idx == BYTE_IDX_W'(1))) begin
          pk_clear = 1'b1;
          if ((len32 == 32'd0) || (len32 > DEPTH)) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            len_d   = len32[ADDR_W:0];
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (pk_valid) begin
          wea_d   = 1'b1;
          dina_d  = pk_word;
          addra_d = words_wr_q[ADDR_W-1:0];
        end
        // The count advances during the write cycle, so the last word
        // is known to be out before the state leaves DATA.
        if (wea_q) begin
          words_wr_d = words_wr_q + 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
          sum_d      = sum_q + dina_q;
          if (words_wr_d == len_q) state_d = ST_SUM;
`else
          if (words_wr_d == len_q) state_d = ST_DONE;
`endif
        end
      end

`ifdef FLASH_LOADER_CHECKSUM_EN
      ST_SUM: begin
        if (pk_valid) begin
          if (pk_word != sum_q) error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        state_d  = ST_IDLE;
        loaded_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    // The inter-byte timeout overrides any transition above. Any partial
    // word is dropped. A write already on the port still completes.
    if (busy_w) begin
      if (accept) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        error_d  = 1'b1;
        state_d  = ST_DONE;
        pk_clear = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      words_wr_q <= '0;
      to_cnt_q   <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
      error_q    <= 1'b0;
      loaded_q   <= 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      words_wr_q <= words_wr_d;
      to_cnt_q   <= to_cnt_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      error_q    <= error_d;
      loaded_q   <= loaded_d;
`ifdef FLASH_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // A reset arriving during a write cycle must stop that write
  // immediately, not one cycle later.
  assign flash_wea   = wea_q && !rst;
  assign flash_addra = addra_q;
  assign flash_dina  = dina_q;
  assign busy        = busy_w;
  assign done        = (state_q == ST_DONE);
  assign error       = error_q;
  assign words_wr    = words_wr_q;
  assign cpu_rst     = !((state_q == ST_DONE) || ((state_q == ST_IDLE) && loaded_q));

endmodule
`default_nettype wire

// File: tb/tb_flash_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_flash_loader
// Purpose : Self-checking bench for flash_loader. It runs the table-driven
//           loads with random data and gaps, then hand-written corner
//           sequences. A queue-based model gives the expected flash
//           contents.
// Rev     : 1.0  initial release
// ============================================================================
module tb_flash_loader;

  localparam int ADDR_W  = 15;
  localparam int DEPTH   = 32768;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] flash_addra;
  logic [31:0]       flash_dina;
  logic              flash_wea;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_wr;

  flash_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .flash_addra(flash_addra), .flash_dina(flash_dina),
    .flash_wea(flash_wea), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .error(error), .words_wr(words_wr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t wr_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Flash-side observer: records each write and checks that no byte is
  // offered as accepted while a write is on the port.
  always @(negedge clk) begin
    if (flash_wea === 1'b1) begin
      wr_log.push_back('{flash_addra, flash_dina});
      chk("ready_low_in_write", {63'd0, rx_ready}, 64'd0);
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
    if (rx_ready === 1'b1) begin
      @(posedge clk);
      #1;
      last_acc = cyc;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int dcyc);
    seen = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 2 * TIMEOUT + 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  // Checks at the done pulse and in the cycle after it, then compares
  // the recorded writes against the expected word list.
  task automatic finish_load(input string tag, input bit exp_err, input int exp_words,
                             input logic [31:0] exp_w[$], input bit exp_timeout);
    bit seen;
    int dcyc;
    wait_done(seen, dcyc);
    chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      chk({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
      chk({tag, "_cpu_rst_at_done"}, {63'd0, cpu_rst}, 64'd0);
      chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      chk({tag, "_words_wr"}, 64'(words_wr), 64'(exp_words));
      if (exp_timeout) chk({tag, "_timeout_cycles"}, 64'(dcyc - last_acc), 64'(TIMEOUT));
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
      if (!exp_err) chk({tag, "_cpu_rst_idle"}, {63'd0, cpu_rst}, 64'd0);
    end
    chk({tag, "_write_count"}, 64'(wr_log.size()), 64'(exp_w.size()));
    for (int i = 0; i < wr_log.size() && i < exp_w.size(); i++) begin
      chk({tag, "_addr"}, 64'(wr_log[i].addr), 64'(i));
      chk({tag, "_data"}, 64'(wr_log[i].data), 64'(exp_w[i]));
    end
  endtask

  typedef struct {
    logic [15:0] n;
    int          nbytes;
    bit          exp_err;
    int          exp_words;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0]  data[$];
    logic [31:0] exp_w[$];
    logic [31:0] sum;
    logic [31:0] w;
    bit          valid;
    int          nw;

    tbl[0] = '{16'd1,      4,  1'b0, 1};
    tbl[1] = '{16'd3,      12, 1'b0, 3};
    tbl[2] = '{16'd0,      0,  1'b1, 0};
    tbl[3] = '{16'hFFFF,   0,  1'b1, 0};
    tbl[4] = '{16'd2,      6,  1'b1, 1};
    tbl[5] = '{16'd5,      20, 1'b0, 5};
    tbl[6] = '{16'd1,      2,  1'b1, 0};
    tbl[7] = '{16'd2,      4,  1'b1, 1};

    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("rst_wea", {63'd0, flash_wea}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_words_wr", 64'(words_wr), 64'd0);
    chk("rst_done_err", {62'd0, done, error}, 64'd0);
    chk("rst_addr_data", {17'd0, flash_addra, flash_dina}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_ready", {63'd0, rx_ready}, 64'd0);
    chk("cpu_rst_before_first_load", {63'd0, cpu_rst}, 64'd1);

    // Table-driven loads with random data and random gaps
    for (int t = 0; t < 8; t++) begin
      data.delete(); exp_w.delete(); wr_log.delete();
      sum = 32'd0;
      pulse_start();
      send_byte(tbl[t].n[7:0], $urandom_range(0, 2));
      send_byte(tbl[t].n[15:8], $urandom_range(0, 2));
      for (int i = 0; i < tbl[t].nbytes; i++) begin
        data.push_back(8'($urandom));
        send_byte(data[i], $urandom_range(0, 3));
      end
      valid = (tbl[t].n != 16'd0) && (int'(tbl[t].n) <= DEPTH);
      nw = valid ? ((tbl[t].nbytes / 4 < int'(tbl[t].n)) ? tbl[t].nbytes / 4 : int'(tbl[t].n)) : 0;
      for (int k = 0; k < nw; k++) begin
        w = {data[4*k+3], data[4*k+2], data[4*k+1], data[4*k]};
        exp_w.push_back(w);
        sum = sum + w;
      end
`ifdef FLASH_LOADER_CHECKSUM_EN
      if (valid && tbl[t].nbytes >= 4 * int'(tbl[t].n)) begin
        send_byte(sum[7:0], 0);   send_byte(sum[15:8], 1);
        send_byte(sum[23:16], 0); send_byte(sum[31:24], 2);
      end
`endif
      finish_load($sformatf("vec%0d", t), tbl[t].exp_err, tbl[t].exp_words, exp_w,
                  valid && (tbl[t].nbytes < 4 * int'(tbl[t].n)));
    end

    // Reference image, with a start pulse in mid-load that must be ignored
    wr_log.delete(); exp_w.delete();
    exp_w.push_back(32'h12345678); exp_w.push_back(32'hDEADBEEF);
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    pulse_start();
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
`ifdef FLASH_LOADER_CHECKSUM_EN
    send_byte(8'h67, 0); send_byte(8'h15, 0); send_byte(8'hE2, 0); send_byte(8'hF0, 0);
`endif
    finish_load("image", 1'b0, 2, exp_w, 1'b0);
    repeat (3) @(negedge clk);
    chk("image_cpu_rst_stays_low", {63'd0, cpu_rst}, 64'd0);

`ifdef FLASH_LOADER_CHECKSUM_EN
    // Same image with a bad checksum
    wr_log.delete();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    finish_load("bad_sum", 1'b1, 2, exp_w, 1'b0);
`endif

    // Oversize length 0x8001
    wr_log.delete(); exp_w.delete();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h80, 0);
    finish_load("oversize", 1'b1, 0, exp_w, 1'b0);

    // Two data bytes, then silence
    wr_log.delete();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    finish_load("timeout", 1'b1, 0, exp_w, 1'b1);

    // Reset during the write cycle of word 1
    wr_log.delete();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wea_dropped", {63'd0, flash_wea}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", {62'd0, busy, done}, 64'd0);
    chk("midrst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("midrst_words_wr", 64'(words_wr), 64'd0);
    repeat (3) @(negedge clk);
    chk("midrst_write_count", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() > 0) begin
      chk("midrst_word0_addr", 64'(wr_log[0].addr), 64'd0);
      chk("midrst_word0_data", 64'(wr_log[0].data), 64'h44332211);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
